memory_access_unit: RTL

Pipeline stage between the Execute Unit and the Write Back Unit of the RV32I core. It accepts load/store requests and ALU results from the Execute Unit and drives a single-port data memory with a req/ready handshake. It handles byte-lane alignment, byte enables and sign/zero extension, and sends results to Write Back. It also supplies the forwarding and stall signals the Execute Unit consumes.

---
 rtl/memory_access_unit_pkg.sv | 37 +++
 rtl/memory_access_unit_lane_align.sv | 43 ++++
 rtl/memory_access_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared types and helpers for the memory access stage: access length codes,
// FSM states, the captured Execute Unit op, and the alignment rule.
package memory_access_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } mau_state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr_r;
    logic [1:0]      len_r;
    logic            is_signed;
    logic            read_en;
    logic [XLEN-1:0] addr_w;
    logic [XLEN-1:0] data_w;
    logic [1:0]      len_w;
    logic            write_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] res;
  } eu_op_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] len);
    case (len)
      LEN_B:   return 1'b0;
      LEN_H:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_unit_lane_align.sv
// Byte-lane handling for one access: byte enables, store replication,
// load lane extraction with sign/zero extension, and the misalign flag.
module mau_lane_align
  import memory_access_unit_pkg::*;
(
  input  logic [1:0]      addr_lo_i,
  input  logic [1:0]      len_i,
  input  logic            is_signed_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] ld_raw_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] st_data_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            misalign_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte    = ld_raw_i[{addr_lo_i, 3'b000} +: 8];
    ld_half    = ld_raw_i[{addr_lo_i[1], 4'b0000} +: 16];
    misalign_o = is_misaligned(addr_lo_i, len_i);
    case (len_i)
      LEN_B: begin
        be_o      = 4'b0001 << addr_lo_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = {{(XLEN-8){is_signed_i & ld_byte[7]}}, ld_byte};
      end
      LEN_H: begin
        be_o      = 4'b0011 << addr_lo_i;
        st_data_o = {2{st_data_i[15:0]}};
        ld_data_o = {{(XLEN-16){is_signed_i & ld_half[15]}}, ld_half};
      end
      default: begin
        be_o      = 4'b1111;
        st_data_o = st_data_i;
        ld_data_o = ld_raw_i;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage of the RV32I core: stage register, IDLE/MEM handshake FSM,
// data memory request drive, forwarding/stall to Execute and registered write-back.
module memory_access_unit
  import memory_access_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] i_eu_addr_r,
  input  logic [1:0]      i_eu_len_r,
  input  logic            i_eu_is_signed,
  input  logic            i_eu_read_en,
  input  logic [XLEN-1:0] i_eu_addr_w,
  input  logic [XLEN-1:0] i_eu_data_w,
  input  logic [1:0]      i_eu_len_w,
  input  logic            i_eu_write_en,
  input  logic [4:0]      i_eu_rd,
  input  logic [XLEN-1:0] i_eu_res,
  output logic [4:0]      o_eu_bypass_reg,
  output logic [XLEN-1:0] o_eu_bypass_data,
  output logic [4:0]      o_eu_reg_not_ready,
  output logic            o_eu_sig_load_x0,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ready,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_misalign
);

  eu_op_t          op_in, stg_q, stg_d;
  mau_state_e      state_q, state_d;
  logic            in_go, stall, mem_busy, ld_done;
  logic            st_store, st_load, st_mem;
  logic [XLEN-1:0] st_addr;
  logic [1:0]      st_len;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_ldata;
  logic            al_misalign;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  // The incoming op's alignment is evaluated here so MEM is entered on the
  // capturing edge and the request rises in the very next cycle.
  always_comb begin
    op_in.addr_r    = i_eu_addr_r;
    op_in.len_r     = i_eu_len_r;
    op_in.is_signed = i_eu_is_signed;
    op_in.read_en   = i_eu_read_en;
    op_in.addr_w    = i_eu_addr_w;
    op_in.data_w    = i_eu_data_w;
    op_in.len_w     = i_eu_len_w;
    op_in.write_en  = i_eu_write_en;
    op_in.rd        = i_eu_rd;
    op_in.res       = i_eu_res;
    in_go = (i_eu_read_en | i_eu_write_en) &
            !is_misaligned(i_eu_write_en ? i_eu_addr_w[1:0] : i_eu_addr_r[1:0],
                           i_eu_write_en ? i_eu_len_w : i_eu_len_r);
  end

  always_comb begin
    mem_busy = (state_q == ST_MEM);
    stall    = mem_busy & !i_dmem_ready;
    st_store = stg_q.write_en;
    st_load  = stg_q.read_en & !stg_q.write_en;
    st_mem   = st_store | st_load;
    st_addr  = st_store ? stg_q.addr_w : stg_q.addr_r;
    st_len   = st_store ? stg_q.len_w : stg_q.len_r;
    ld_done  = mem_busy & st_load & i_dmem_ready;
  end

  mau_lane_align u_align (
    .addr_lo_i   (st_addr[1:0]),
    .len_i       (st_len),
    .is_signed_i (stg_q.is_signed),
    .st_data_i   (stg_q.data_w),
    .ld_raw_i    (i_dmem_rdata),
    .be_o        (al_be),
    .st_data_o   (al_wdata),
    .ld_data_o   (al_ldata),
    .misalign_o  (al_misalign)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = in_go ? ST_MEM : ST_IDLE;
      ST_MEM:  if (i_dmem_ready) state_d = in_go ? ST_MEM : ST_IDLE;
    endcase
    stg_d = stall ? stg_q : op_in;
  end

  always_comb begin
    o_dmem_req         = mem_busy;
    o_dmem_we          = mem_busy & st_store;
    o_dmem_addr        = mem_busy ? {st_addr[XLEN-1:2], 2'b00} : '0;
    o_dmem_be          = mem_busy ? al_be : '0;
    o_dmem_wdata       = (mem_busy & st_store) ? al_wdata : '0;
    o_eu_sig_load_x0   = stall;
    o_misalign         = st_mem & al_misalign;
    o_eu_reg_not_ready = (mem_busy & st_load) ? stg_q.rd : '0;
    fwd_rd             = '0;
    fwd_data           = '0;
    if (!st_mem) begin
      fwd_rd   = stg_q.rd;
      fwd_data = stg_q.res;
    end else if (ld_done) begin
      fwd_rd   = stg_q.rd;
      fwd_data = al_ldata;
    end
    if (fwd_rd == 5'd0) fwd_data = '0;
    o_eu_bypass_reg  = fwd_rd;
    o_eu_bypass_data = fwd_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      stg_q     <= stg_d;
      wb_rd_q   <= fwd_rd;
      wb_data_q <= fwd_data;
    end
  end

  assign o_wb_rd   = wb_rd_q;
  assign o_wb_data = wb_data_q;

endmodule
